// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 UART transmitter, LSB first, valid/ready byte intake, registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_frame #(
  parameter int P_BIT_CNT   = 433,
  parameter int P_DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_out,
  output logic       tx_busy,
  output logic       tx_done
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t     r_state, w_state_nxt;
  logic [8:0] r_cnt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_out, w_out_nxt;
  logic       w_bnd;
`ifdef UART_TX_PARITY_EN
  logic       r_par;
`endif
  assign w_bnd    = r_cnt == 9'(P_BIT_CNT);
  assign tx_ready = r_state == S_IDLE;
  assign tx_busy  = r_state != S_IDLE;
  assign tx_done  = r_state == S_STOP && w_bnd;
  assign uart_out = r_out;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_out   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == S_IDLE || w_bnd) ? 9'd0 : r_cnt + 9'd1;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_out   <= w_out_nxt;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) r_par <= 1'b0;
    else if (r_state == S_IDLE && tx_valid) r_par <= ^tx_data;
`endif
  // Line level is computed for the state being entered so uart_out stays registered.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_out_nxt   = r_out;
    case (r_state)
      S_IDLE: begin
        w_out_nxt = 1'b1;
        if (tx_valid) begin
          w_state_nxt = S_START;
          w_shift_nxt = tx_data;
          w_idx_nxt   = '0;
          w_out_nxt   = 1'b0;
        end
      end
      S_START: if (w_bnd) begin
        w_state_nxt = S_DATA;
        w_out_nxt   = r_shift[0];
      end
      S_DATA: if (w_bnd) begin
        if (r_idx == 3'(P_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
          w_out_nxt   = r_par;
`else
          w_state_nxt = S_STOP;
          w_out_nxt   = 1'b1;
`endif
        end else begin
          w_idx_nxt   = r_idx + 3'd1;
          w_shift_nxt = r_shift >> 1;
          w_out_nxt   = r_shift[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (w_bnd) begin
        w_state_nxt = S_STOP;
        w_out_nxt   = 1'b1;
      end
`endif
      S_STOP: if (w_bnd) begin
        w_state_nxt = S_IDLE;
        w_out_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_out_nxt   = 1'b1;
      end
    endcase
  end
endmodule
